// File: rtl/resp_checker.sv
// Response checker: compares captured DUT vectors against a masked golden memory.
// It also compacts every accepted response into a MISR signature.
module resp_checker #(
  parameter int               WIDTH     = 22,
  parameter int               DEPTH     = 10,
  parameter int               IDX_W     = 4,
  parameter logic [WIDTH-1:0] MISR_POLY = 22'h200003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_addr,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic             start,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   fail_count,
  output logic             first_fail_valid,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] signature
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   FC_MAX   = {(IDX_W + 1){1'b1}};

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? MISR_POLY : {WIDTH{1'b0}};
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ data;
  endfunction

  function automatic logic is_mismatch(input logic [WIDTH-1:0] resp,
                                       input logic [WIDTH-1:0] expv,
                                       input logic [WIDTH-1:0] mask);
    return |((resp ^ expv) & mask);
  endfunction

  logic [WIDTH-1:0] mem_data_r [DEPTH];
  logic [WIDTH-1:0] mem_mask_r [DEPTH];

  state_t           state_r, next_state_s;
  logic             resp_ready_r, busy_r, done_r, pass_r;
  logic             ready_nxt_s, busy_nxt_s, done_nxt_s, pass_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [IDX_W:0]   fc_r, fc_nxt_s;
  logic             ffv_r, ffv_nxt_s;
  logic [IDX_W-1:0] ffi_r, ffi_nxt_s;
  logic [WIDTH-1:0] sig_r, sig_nxt_s;
  logic             wr_en_s, accept_s, start_go_s, mismatch_s;

  assign wr_en_s    = exp_we & ({1'b0, exp_addr} < DEPTH_W) & ~busy_r;
  assign accept_s   = resp_valid & resp_ready_r;
  assign start_go_s = start & (state_r != RUN);
  assign mismatch_s = is_mismatch(resp_data, mem_data_r[idx_r], mem_mask_r[idx_r]);

  // Golden memory write port; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_data_r[exp_addr] <= exp_data;
      mem_mask_r[exp_addr] <= exp_mask;
    end
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      resp_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      resp_ready_r <= ready_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (accept_s && (idx_r == LAST_IDX)) next_state_s = DONE;
        else                                 next_state_s = RUN;
      end
      DONE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered.
  always_comb begin
    ready_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    case (next_state_s)
      IDLE: begin
        ready_nxt_s = 1'b0;
      end
      RUN: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      DONE: begin
        done_nxt_s = 1'b1;
      end
      default: begin
        ready_nxt_s = 1'b0;
      end
    endcase
    pass_nxt_s = done_nxt_s & (fc_nxt_s == {(IDX_W + 1){1'b0}});
  end

  // Result datapath next values: clear on start, update on accept.
  always_comb begin
    idx_nxt_s = idx_r;
    fc_nxt_s  = fc_r;
    ffv_nxt_s = ffv_r;
    ffi_nxt_s = ffi_r;
    sig_nxt_s = sig_r;
    if (start_go_s) begin
      idx_nxt_s = {IDX_W{1'b0}};
      fc_nxt_s  = {(IDX_W + 1){1'b0}};
      ffv_nxt_s = 1'b0;
      ffi_nxt_s = {IDX_W{1'b0}};
      sig_nxt_s = {WIDTH{1'b0}};
    end else if (accept_s) begin
      sig_nxt_s = misr_step(sig_r, resp_data);
      if (idx_r == LAST_IDX) idx_nxt_s = {IDX_W{1'b0}};
      else                   idx_nxt_s = idx_r + IDX_W'(1);
      if (mismatch_s) begin
        if (fc_r == FC_MAX) fc_nxt_s = fc_r;
        else                fc_nxt_s = fc_r + (IDX_W + 1)'(1);
        if (!ffv_r) begin
          ffv_nxt_s = 1'b1;
          ffi_nxt_s = idx_r;
        end else begin
          ffv_nxt_s = ffv_r;
          ffi_nxt_s = ffi_r;
        end
      end else begin
        fc_nxt_s = fc_r;
      end
    end else begin
      sig_nxt_s = sig_r;
    end
  end

  // Result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
      fc_r  <= {(IDX_W + 1){1'b0}};
      ffv_r <= 1'b0;
      ffi_r <= {IDX_W{1'b0}};
      sig_r <= {WIDTH{1'b0}};
    end else begin
      idx_r <= idx_nxt_s;
      fc_r  <= fc_nxt_s;
      ffv_r <= ffv_nxt_s;
      ffi_r <= ffi_nxt_s;
      sig_r <= sig_nxt_s;
    end
  end

  assign resp_ready       = resp_ready_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign fail_count       = fc_r;
  assign first_fail_valid = ffv_r;
  assign first_fail_idx   = ffi_r;
  assign signature        = sig_r;

endmodule

// File: tb/tb_resp_checker.sv
// Scoreboard bench for resp_checker: a reference model predicts each session's
// results, and a negedge monitor compares them while done is high.
module tb_resp_checker;
  localparam int WIDTH = 22;
  localparam int DEPTH = 10;
  localparam int IDX_W = 4;
  localparam logic [WIDTH-1:0] POLY = 22'h200003;
  localparam logic [WIDTH-1:0] ONES = 22'h3FFFFF;

  logic             clk = 1'b0;
  logic             rst;
  logic             exp_we;
  logic [IDX_W-1:0] exp_addr;
  logic [WIDTH-1:0] exp_data, exp_mask;
  logic             start, resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_ready, busy, done, pass;
  logic [IDX_W:0]   fail_count;
  logic             first_fail_valid;
  logic [IDX_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] signature;

  resp_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .MISR_POLY(POLY)) dut (
    .clk(clk), .rst(rst), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_mask(exp_mask), .start(start), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx), .signature(signature)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W:0]   fc;
    logic             ffv;
    logic [IDX_W-1:0] ffi;
    logic             pass;
    logic [WIDTH-1:0] sig;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] model_data [DEPTH];
  logic [WIDTH-1:0] model_mask [DEPTH];
  logic [WIDTH-1:0] resp_vec [DEPTH];
  int               tests = 0;
  int               fails = 0;
  bit               in_session = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: walk the vector list with plain arithmetic.
  function automatic exp_t model_result();
    exp_t r;
    int   nfail;
    r = '0;
    nfail = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((resp_vec[i] ^ model_data[i]) & model_mask[i]) != 0) begin
        if (nfail < 31) nfail++;
        if (!r.ffv) begin
          r.ffv = 1'b1;
          r.ffi = 4'(i);
        end
      end
      r.sig = {r.sig[WIDTH-2:0], 1'b0} ^ (r.sig[WIDTH-1] ? POLY : 22'h0) ^ resp_vec[i];
    end
    r.fc   = 5'(nfail);
    r.pass = (nfail == 0);
    return r;
  endfunction

  task automatic write_mem(input int addr, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    exp_we   = 1'b1;
    exp_addr = addr[IDX_W-1:0];
    exp_data = d;
    exp_mask = m;
    if (!in_session && addr < DEPTH) begin
      model_data[addr] = d;
      model_mask[addr] = m;
    end
    @(posedge clk); #1;
    exp_we = 1'b0;
  endtask

  task automatic start_session(input bit do_push, input bit with_write, input int addr,
                               input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    start = 1'b1;
    if (with_write) begin
      exp_we   = 1'b1;
      exp_addr = addr[IDX_W-1:0];
      exp_data = d;
      exp_mask = m;
      if (addr < DEPTH) begin
        model_data[addr] = d;
        model_mask[addr] = m;
      end
    end
    if (do_push) sb_q.push_back(model_result());
    @(posedge clk); #1;
    start      = 1'b0;
    exp_we     = 1'b0;
    in_session = 1'b1;
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random gaps plus stray start pulses.
  task automatic send_resps(input int mode, input int count);
    int i, cyc;
    bit v, acc;
    i = 0;
    cyc = 0;
    while (i < count && cyc < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      resp_valid = v;
      resp_data  = v ? resp_vec[i] : WIDTH'($urandom);
      start      = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      acc = resp_valid && resp_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    resp_valid = 1'b0;
    start      = 1'b0;
    if (i < count) check("accept_timeout", 32'(i), 32'(count));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    in_session = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_full(input int mode);
    start_session(1'b1, 1'b0, 0, 22'h0, 22'h0);
    send_resps(mode, DEPTH);
    wait_done();
  endtask

  task automatic set_identity();
    for (int i = 0; i < DEPTH; i++) resp_vec[i] = WIDTH'(i);
  endtask

  // Monitor: pop one expectation per done rise, hold it while done stays high.
  logic done_d = 1'b0;
  int   acc_cnt = 0;
  bit   acc_prev = 1'b0;
  exp_t cur = '0;
  always @(negedge clk) begin
    if (rst) begin
      acc_cnt  = 0;
      acc_prev = 1'b0;
      done_d   = 1'b0;
    end else begin
      if (done && !done_d) begin
        if (sb_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
        else cur = sb_q.pop_front();
        check("accepts", 32'(acc_cnt), 32'(DEPTH));
        check("done_latency", 32'(acc_prev), 32'd1);
        acc_cnt = 0;
      end
      if (done) begin
        check("fail_count", 32'(fail_count), 32'(cur.fc));
        check("first_fail_valid", 32'(first_fail_valid), 32'(cur.ffv));
        check("first_fail_idx", 32'(first_fail_idx), 32'(cur.ffi));
        check("pass", 32'(pass), 32'(cur.pass));
        check("signature", 32'(signature), 32'(cur.sig));
        check("busy_in_done", 32'(busy | resp_ready), 32'd0);
      end else begin
        check("pass_outside_done", 32'(pass), 32'd0);
      end
      acc_prev = resp_valid && resp_ready;
      if (acc_prev) acc_cnt++;
      done_d = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] d;
    rst = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_mask = '0;
    start = 1'b0; resp_valid = 1'b0; resp_data = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(resp_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_ffv", 32'(first_fail_valid), 32'd0);
    check("rst_ffi", 32'(first_fail_idx), 32'd0);
    check("rst_signature", 32'(signature), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) write_mem(i, WIDTH'(i), ONES);

    // All-match session.
    set_identity();
    run_full(0);

    // Mismatches on vectors 3 and 7.
    resp_vec[3] ^= 22'h1;
    resp_vec[7] ^= 22'h1;
    run_full(0);

    // Masked-off bit 0 on entry 5.
    write_mem(5, WIDTH'(5), 22'h3FFFFE);
    set_identity();
    resp_vec[5] ^= 22'h1;
    run_full(0);
    write_mem(5, WIDTH'(5), ONES);

    // Alternating resp_valid gaps.
    set_identity();
    run_full(1);

    // Asynchronous reset after the 4th accept, then a clean rerun.
    start_session(1'b0, 1'b0, 0, 22'h0, 22'h0);
    send_resps(0, 4);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(resp_ready), 32'd0);
    check("abort_fail_count", 32'(fail_count), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    in_session = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    run_full(0);

    // Write attempt during RUN must be ignored; two identical sessions follow.
    start_session(1'b1, 1'b0, 0, 22'h0, 22'h0);
    write_mem(2, 22'h2ABCDE, ONES);
    send_resps(0, DEPTH);
    wait_done();
    run_full(0);

    // Out-of-range write must be ignored.
    write_mem(12, 22'h155555, ONES);

    // Write coincident with start: session must see the new entry.
    d = 22'h0F0F0F;
    resp_vec[4] = d;
    start_session(1'b1, 1'b1, 4, d, ONES);
    send_resps(0, DEPTH);
    wait_done();

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 3; k++)
        write_mem($urandom_range(0, 15), WIDTH'($urandom), WIDTH'($urandom));
      for (int i = 0; i < DEPTH; i++)
        resp_vec[i] = model_data[i] ^ (($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : 22'h0);
      run_full($urandom_range(0, 2));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
